// File: rtl/rvh_mmu_pkg.sv
// ============================================================================
//  Module      : rvh_mmu_pkg
//  Description : Shared widths, access-type encodings and flush-FSM state
//                encodings for the MMU miss front end.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvh_mmu_pkg;

    localparam int ASID_WIDTH = 16;
    localparam int PTE_WIDTH  = 64;
    localparam int PPN_WIDTH  = 44;

    typedef enum logic [1:0] {
        ACCESS_R = 2'd0,
        ACCESS_W = 2'd1,
        ACCESS_X = 2'd2
    } access_type_e;

    // Flush handshake FSM encodings
    typedef logic [1:0] flush_state_t;
    localparam flush_state_t FLUSH_IDLE  = 2'd0;
    localparam flush_state_t FLUSH_DRAIN = 2'd1;
    localparam flush_state_t FLUSH_GRANT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rvh_mmu_rr_arb.sv
// ============================================================================
//  Module      : rvh_mmu_rr_arb
//  Description : Parametric round-robin arbiter. Grants the first requester
//                at or above the internal pointer (with wrap-around); the
//                pointer moves past the granted port when i_advance is high.
//  Ports       : clk, rstn          clock, async active-low reset
//                i_req[PORT_NUM]    request vector
//                i_advance          grant was consumed this cycle
//                o_grant            one-hot grant (combinational)
//                o_grant_idx        binary index of the granted port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvh_mmu_rr_arb #(
    parameter int PORT_NUM      = 2,
    parameter int PORT_ID_WIDTH = $clog2(PORT_NUM)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [PORT_NUM-1:0]      i_req,
    input  logic                     i_advance,
    output logic [PORT_NUM-1:0]      o_grant,
    output logic [PORT_ID_WIDTH-1:0] o_grant_idx
);

    localparam logic [PORT_ID_WIDTH-1:0] c_last_port = PORT_ID_WIDTH'(PORT_NUM - 1);

    logic [PORT_ID_WIDTH-1:0] r_ptr;
    logic [PORT_ID_WIDTH-1:0] w_cand;
    logic                     w_found;

    // Walk the ports starting at r_ptr; the first requester wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            w_cand = PORT_ID_WIDTH'((int'(r_ptr) + k) % PORT_NUM);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == c_last_port) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rvh_mmu_miss_arb.sv
// ============================================================================
//  Module      : rvh_mmu_miss_arb
//  Description : N-port TLB-miss front end for the PTW. Round-robin
//                arbitrates miss ports onto one translate port, records the
//                issuing port of every in-flight walk in a tag FIFO and
//                routes each in-order PTW response back to that port. Also
//                owns the TLB flush handshake (drain walks, then grant).
//  Ports       : clk, rstn                 clock, async active-low reset
//                miss_req_*                per-port miss requests (flattened)
//                miss_resp_*               one-hot valid + broadcast payload
//                translate_req_*/resp_*    PTW request/response
//                tlb_flush_vld_i/grant_o   flush handshake
//                perf_req_cnt_o            per-port accept counters
//                                          (only with MMU_MISS_ARB_PERF_EN)
//  Config      : `define MMU_MISS_ARB_PERF_EN adds 32-bit per-port counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvh_mmu_miss_arb
    import rvh_mmu_pkg::*;
#(
    parameter int PORT_NUM       = 2,
    parameter int TRANS_ID_WIDTH = 3,
    parameter int VPN_WIDTH      = 27,
    parameter int PAGE_LVL_WIDTH = 2,
    parameter int OUTSTANDING    = 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [PORT_NUM-1:0]                miss_req_vld_i,
    input  logic [PORT_NUM*TRANS_ID_WIDTH-1:0] miss_req_trans_id_i,
    input  logic [PORT_NUM*ASID_WIDTH-1:0]     miss_req_asid_i,
    input  logic [PORT_NUM*VPN_WIDTH-1:0]      miss_req_vpn_i,
    input  logic [PORT_NUM*2-1:0]              miss_req_access_type_i,
    output logic [PORT_NUM-1:0]                miss_req_rdy_o,
    output logic [PORT_NUM-1:0]                miss_resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0]          miss_resp_trans_id_o,
    output logic [ASID_WIDTH-1:0]              miss_resp_asid_o,
    output logic [PTE_WIDTH-1:0]               miss_resp_pte_o,
    output logic [PAGE_LVL_WIDTH-1:0]          miss_resp_page_lvl_o,
    output logic [VPN_WIDTH-1:0]               miss_resp_vpn_o,
    output logic [1:0]                         miss_resp_access_type_o,
    output logic                               miss_resp_access_fault_o,
    output logic                               miss_resp_page_fault_o,
    output logic                               translate_req_vld_o,
    output logic [TRANS_ID_WIDTH-1:0]          translate_req_trans_id_o,
    output logic [ASID_WIDTH-1:0]              translate_req_asid_o,
    output logic [VPN_WIDTH-1:0]               translate_req_vpn_o,
    output logic [1:0]                         translate_req_access_type_o,
    input  logic                               translate_req_rdy_i,
    input  logic                               translate_resp_vld_i,
    input  logic [TRANS_ID_WIDTH-1:0]          translate_resp_trans_id_i,
    input  logic [ASID_WIDTH-1:0]              translate_resp_asid_i,
    input  logic [PTE_WIDTH-1:0]               translate_resp_pte_i,
    input  logic [PAGE_LVL_WIDTH-1:0]          translate_resp_page_lvl_i,
    input  logic [VPN_WIDTH-1:0]               translate_resp_vpn_i,
    input  logic [1:0]                         translate_resp_access_type_i,
    input  logic                               translate_resp_access_fault_i,
    input  logic                               translate_resp_page_fault_i,
    input  logic                               tlb_flush_vld_i,
    output logic                               tlb_flush_grant_o
`ifdef MMU_MISS_ARB_PERF_EN
    ,
    output logic [PORT_NUM*32-1:0]             perf_req_cnt_o
`endif
);

    localparam int PORT_ID_WIDTH = $clog2(PORT_NUM);
    localparam int CNT_WIDTH     = $clog2(OUTSTANDING + 1);
    localparam int PTR_WIDTH     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    localparam logic [CNT_WIDTH-1:0] c_depth     = CNT_WIDTH'(OUTSTANDING);
    localparam logic [PTR_WIDTH-1:0] c_last_slot = PTR_WIDTH'(OUTSTANDING - 1);

    logic [PORT_NUM-1:0]       w_grant;
    logic [PORT_ID_WIDTH-1:0]  w_grant_idx;
    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic [PORT_ID_WIDTH-1:0]  w_head;

    logic [PORT_ID_WIDTH-1:0]  r_tag [OUTSTANDING];
    logic [PTR_WIDTH-1:0]      r_wr_ptr;
    logic [PTR_WIDTH-1:0]      r_rd_ptr;
    logic [CNT_WIDTH-1:0]      r_cnt;

    flush_state_t              r_state;
    flush_state_t              w_state_nxt;

    // ------------------------------------------------------------------
    // Arbitration and request path
    // ------------------------------------------------------------------
    rvh_mmu_rr_arb #(
        .PORT_NUM      (PORT_NUM),
        .PORT_ID_WIDTH (PORT_ID_WIDTH)
    ) u_rr_arb (
        .clk         (clk),
        .rstn        (rstn),
        .i_req       (miss_req_vld_i),
        .i_advance   (w_push),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // The full check uses the registered count only, so a same-cycle pop
    // never opens a slot; this keeps responses off the request timing path.
    assign w_accept = (|miss_req_vld_i) & (r_cnt < c_depth) &
                      (r_state == FLUSH_IDLE) & ~tlb_flush_vld_i;
    assign w_push   = w_accept & translate_req_rdy_i;

    assign translate_req_vld_o = w_accept;
    assign miss_req_rdy_o      = {PORT_NUM{w_push}} & w_grant;

    always_comb begin
        translate_req_trans_id_o    = '0;
        translate_req_asid_o        = '0;
        translate_req_vpn_o         = '0;
        translate_req_access_type_o = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_grant[p]) begin
                translate_req_trans_id_o    = miss_req_trans_id_i[p*TRANS_ID_WIDTH +: TRANS_ID_WIDTH];
                translate_req_asid_o        = miss_req_asid_i[p*ASID_WIDTH +: ASID_WIDTH];
                translate_req_vpn_o         = miss_req_vpn_i[p*VPN_WIDTH +: VPN_WIDTH];
                translate_req_access_type_o = miss_req_access_type_i[p*2 +: 2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Port-tag FIFO
    // ------------------------------------------------------------------
    // A response arriving with nothing in flight is stale (e.g. issued
    // before a reset) and is dropped rather than popping an empty FIFO.
    assign w_pop  = translate_resp_vld_i & (r_cnt != '0);
    assign w_head = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_slot) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_slot) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing: valid to the tagged port, payload broadcast
    // ------------------------------------------------------------------
    always_comb begin
        miss_resp_vld_o = '0;
        if (w_pop) begin
            miss_resp_vld_o[w_head] = 1'b1;
        end
    end

    assign miss_resp_trans_id_o     = translate_resp_trans_id_i;
    assign miss_resp_asid_o         = translate_resp_asid_i;
    assign miss_resp_pte_o          = translate_resp_pte_i;
    assign miss_resp_page_lvl_o     = translate_resp_page_lvl_i;
    assign miss_resp_vpn_o          = translate_resp_vpn_i;
    assign miss_resp_access_type_o  = translate_resp_access_type_i;
    assign miss_resp_access_fault_o = translate_resp_access_fault_i;
    assign miss_resp_page_fault_o   = translate_resp_page_fault_i;

    // ------------------------------------------------------------------
    // Flush handshake FSM
    // ------------------------------------------------------------------
    // Withdrawing the flush request while draining takes priority over an
    // empty FIFO, so a grant is never issued to a requester that has left.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FLUSH_IDLE: begin
                if (tlb_flush_vld_i) begin
                    w_state_nxt = FLUSH_DRAIN;
                end
            end
            FLUSH_DRAIN: begin
                if (!tlb_flush_vld_i) begin
                    w_state_nxt = FLUSH_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = FLUSH_GRANT;
                end
            end
            FLUSH_GRANT: w_state_nxt = FLUSH_IDLE;
            default:     w_state_nxt = FLUSH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= FLUSH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign tlb_flush_grant_o = (r_state == FLUSH_GRANT);

    // ------------------------------------------------------------------
    // Optional per-port accept counters
    // ------------------------------------------------------------------
`ifdef MMU_MISS_ARB_PERF_EN
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_perf_cnt
        logic [31:0] r_req_cnt;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_req_cnt <= '0;
            end else if (w_push && w_grant[p]) begin
                r_req_cnt <= r_req_cnt + 32'd1;
            end
        end
        assign perf_req_cnt_o[p*32 +: 32] = r_req_cnt;
    end
`endif

endmodule

`default_nettype wire
